// File: rtl/rfphoenix_icvalid_sweep.sv
// I-cache valid-bit controller: per-way valid array, queued line/all invalidates, index sweep.
// Optional macro RFPHOENIX_ICVALID_FASTINV_EN: invalidate-all clears the whole array in one cycle.
module rfphoenix_icvalid_sweep #(
  parameter int LINES  = 128,
  parameter int WAYS   = 4,
  parameter int LOBIT  = 7,
  parameter int ABITS  = 32,
  parameter int QDEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ABITS-1:0]        lkp_adr,
  output logic [WAYS-1:0]         vld_o,
  input  logic                    fill_wr,
  input  logic [$clog2(WAYS)-1:0] fill_way,
  input  logic [ABITS-1:0]        fill_adr,
  input  logic                    inv_req,
  input  logic                    inv_all,
  input  logic [ABITS-1:0]        inv_adr,
  output logic                    inv_rdy,
  output logic                    busy,
  output logic                    inv_done
);

  localparam int IW = $clog2(LINES);
  localparam int QW = $clog2(QDEPTH);
  localparam logic [QW:0]   QFULL = (QW+1)'(QDEPTH);
  localparam logic [IW-1:0] LAST  = IW'(LINES - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t          state_q;
  logic [IW-1:0]   ptr_q;
  logic [QW:0]     cnt_q;
  logic [QW-1:0]   rd_q, wr_q;
  logic [IW:0]     q_mem [QDEPTH];
  logic [WAYS-1:0] valid_q [LINES];

  logic [IW-1:0] lkp_idx, fill_idx, inv_idx, head_idx, clr_idx;
  logic          head_all, push, pop;
  logic          clr_line, clr_every, enter_sweep, done_d;
  logic          unused_adr_bits;

  assign lkp_idx  = lkp_adr[LOBIT+IW-1:LOBIT];
  assign fill_idx = fill_adr[LOBIT+IW-1:LOBIT];
  assign inv_idx  = inv_adr[LOBIT+IW-1:LOBIT];
  assign unused_adr_bits = ^{lkp_adr, fill_adr, inv_adr};

  // Readiness comes from the count alone, so a full queue refuses a push even while popping.
  assign inv_rdy  = (cnt_q != QFULL);
  assign push     = inv_req && inv_rdy;
  assign pop      = (state_q == IDLE) && (cnt_q != '0);
  assign head_all = q_mem[rd_q][IW];
  assign head_idx = q_mem[rd_q][IW-1:0];
  assign busy     = (cnt_q != '0) || (state_q == SWEEP);

  always_comb begin
    clr_line    = 1'b0;
    clr_idx     = ptr_q;
    clr_every   = 1'b0;
    enter_sweep = 1'b0;
    done_d      = 1'b0;
    if (state_q == SWEEP) begin
      clr_line = 1'b1;
      done_d   = (ptr_q == LAST);
    end else if (pop) begin
      if (head_all) begin
`ifdef RFPHOENIX_ICVALID_FASTINV_EN
        clr_every = 1'b1;
        done_d    = 1'b1;
`else
        enter_sweep = 1'b1;
`endif
      end else begin
        clr_line = 1'b1;
        clr_idx  = head_idx;
      end
    end
  end

  // Queue payload carries no reset; only the pointers and count qualify it.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_q] <= {inv_all, inv_idx};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      vld_o    <= '0;
      inv_done <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + QW'(1);
      if (pop)  rd_q <= rd_q + QW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (QW+1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (QW+1)'(1);

      if (enter_sweep) begin
        state_q <= SWEEP;
        ptr_q   <= '0;
      end else if (state_q == SWEEP) begin
        ptr_q <= ptr_q + IW'(1);
        if (ptr_q == LAST) state_q <= IDLE;
      end

      inv_done <= done_d;
      if ((state_q == SWEEP) || enter_sweep) vld_o <= '0;
      else                                   vld_o <= valid_q[lkp_idx];
    end
  end

  // Clear first, then fill, so a same-index fill survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) valid_q[i] <= '0;
    end else begin
      for (int i = 0; i < LINES; i++) begin
        if (clr_every || (clr_line && (clr_idx == IW'(i)))) valid_q[i] <= '0;
        if (fill_wr && (fill_idx == IW'(i)))                valid_q[i][fill_way] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rfphoenix_icvalid_sweep.sv
// Bench for rfphoenix_icvalid_sweep: vector table, hand sequences and a random run against a queue model.
module tb_rfphoenix_icvalid_sweep;
  localparam int LINES = 128, WAYS = 4, LOBIT = 7, ABITS = 32, QDEPTH = 4;
`ifdef RFPHOENIX_ICVALID_FASTINV_EN
  localparam int INVALL_K = 1;
`else
  localparam int INVALL_K = LINES + 1;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [ABITS-1:0] lkp_adr = '0, fill_adr = '0, inv_adr = '0;
  logic [WAYS-1:0]  vld_o;
  logic fill_wr = 1'b0, inv_req = 1'b0, inv_all = 1'b0;
  logic [1:0] fill_way = '0;
  logic inv_rdy, busy, inv_done;

  rfphoenix_icvalid_sweep #(.LINES(LINES), .WAYS(WAYS), .LOBIT(LOBIT), .ABITS(ABITS), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst), .lkp_adr(lkp_adr), .vld_o(vld_o), .fill_wr(fill_wr), .fill_way(fill_way),
    .fill_adr(fill_adr), .inv_req(inv_req), .inv_all(inv_all), .inv_adr(inv_adr),
    .inv_rdy(inv_rdy), .busy(busy), .inv_done(inv_done));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: array of bits, FIFO of pending invalidates, sweep position (-1 = none).
  typedef struct { bit all; int idx; } qe_t;
  bit [WAYS-1:0] m_arr [LINES];
  qe_t m_q[$];
  int  m_sweep;
  bit  m_done;
  bit [WAYS-1:0] m_vld;

  function automatic int idx_of(input logic [ABITS-1:0] a);
    return int'(a[LOBIT +: 7]);
  endfunction

  task automatic model_reset();
    foreach (m_arr[i]) m_arr[i] = '0;
    m_q.delete();
    m_sweep = -1; m_done = 0; m_vld = '0;
  endtask

  task automatic model_edge();
    int  sz0 = m_q.size();
    bit  was_sweep = (m_sweep >= 0);
    bit  entering = 0, nd = 0, wipe = 0;
    int  cl = -1;
    qe_t h;
    if (was_sweep) begin
      cl = m_sweep;
      if (m_sweep == LINES - 1) begin nd = 1; m_sweep = -1; end
      else m_sweep++;
    end else if (sz0 > 0) begin
      h = m_q.pop_front();
      if (h.all) begin
`ifdef RFPHOENIX_ICVALID_FASTINV_EN
        wipe = 1; nd = 1;
`else
        m_sweep = 0; entering = 1;
`endif
      end else cl = h.idx;
    end
    m_vld = (was_sweep || entering) ? '0 : m_arr[idx_of(lkp_adr)];
    if (inv_req && sz0 < QDEPTH) begin
      h.all = inv_all; h.idx = idx_of(inv_adr);
      m_q.push_back(h);
    end
    if (wipe) foreach (m_arr[i]) m_arr[i] = '0;
    if (cl >= 0) m_arr[cl] = '0;
    if (fill_wr) m_arr[idx_of(fill_adr)][fill_way] = 1'b1;
    m_done = nd;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk); #1;
    chk("mdl_vld", 32'(vld_o), 32'(m_vld));
    chk("mdl_rdy", 32'(inv_rdy), 32'(m_q.size() < QDEPTH));
    chk("mdl_busy", 32'(busy), 32'(m_q.size() != 0 || m_sweep >= 0));
    chk("mdl_done", 32'(inv_done), 32'(m_done));
  endtask

  task automatic idle_inputs();
    fill_wr = 0; inv_req = 0; inv_all = 0;
  endtask

  typedef struct {
    logic fw; logic [1:0] way; logic [31:0] fa;
    logic ir; logic ia; logic [31:0] iad; logic [31:0] la;
    logic [3:0] vld; logic rdy; logic bsy;
  } vec_t;
  vec_t tv[16];

  int busy_cnt, done_n, done_k;

  initial begin
    tv[0]  = '{1, 2, 32'h480, 0, 0, 0, 32'h480, 4'h0, 1, 0};
    tv[1]  = '{1, 0, 32'h480, 0, 0, 0, 32'h480, 4'h4, 1, 0};
    tv[2]  = '{1, 1, 32'h480, 0, 0, 0, 32'h480, 4'h5, 1, 0};
    tv[3]  = '{1, 3, 32'h480, 0, 0, 0, 32'h480, 4'h7, 1, 0};
    tv[4]  = '{1, 0, 32'h400, 0, 0, 0, 32'h480, 4'hF, 1, 0};
    tv[5]  = '{0, 0, 0, 1, 0, 32'h480, 32'h480, 4'hF, 1, 1};
    tv[6]  = '{0, 0, 0, 0, 0, 0, 32'h480, 4'hF, 1, 0};
    tv[7]  = '{0, 0, 0, 0, 0, 0, 32'h480, 4'h0, 1, 0};
    tv[8]  = '{0, 0, 0, 0, 0, 0, 32'h400, 4'h1, 1, 0};
    tv[9]  = '{1, 0, 32'h180, 0, 0, 0, 32'h480, 4'h0, 1, 0};
    tv[10] = '{1, 1, 32'h180, 0, 0, 0, 32'h180, 4'h1, 1, 0};
    tv[11] = '{1, 2, 32'h180, 0, 0, 0, 32'h180, 4'h3, 1, 0};
    tv[12] = '{1, 3, 32'h180, 0, 0, 0, 32'h180, 4'h7, 1, 0};
    tv[13] = '{0, 0, 0, 1, 0, 32'h180, 32'h180, 4'hF, 1, 1};
    tv[14] = '{1, 1, 32'h180, 0, 0, 0, 32'h180, 4'hF, 1, 0};
    tv[15] = '{0, 0, 0, 0, 0, 0, 32'h180, 4'h2, 1, 0};

    // Reset state
    model_reset();
    #3;
    chk("rst_vld", 32'(vld_o), 0);
    chk("rst_rdy", 32'(inv_rdy), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(inv_done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Vector table: fills, line invalidate, fill/clear collision
    for (int i = 0; i < 16; i++) begin
      fill_wr = tv[i].fw; fill_way = tv[i].way; fill_adr = tv[i].fa;
      inv_req = tv[i].ir; inv_all = tv[i].ia; inv_adr = tv[i].iad; lkp_adr = tv[i].la;
      tick();
      chk($sformatf("tv%0d_vld", i), 32'(vld_o), 32'(tv[i].vld));
      chk($sformatf("tv%0d_rdy", i), 32'(inv_rdy), 32'(tv[i].rdy));
      chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].bsy));
    end
    idle_inputs();

    // Random traffic over a small index set so hits, collisions and full queues occur
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] a;
      fill_wr  = ($urandom_range(3, 0) != 0);
      fill_way = 2'($urandom_range(3, 0));
      a = $urandom; a[13:7] = 7'($urandom_range(15, 0)); fill_adr = a;
      a = $urandom; a[13:7] = 7'($urandom_range(15, 0)); lkp_adr = a;
      a = $urandom; a[13:7] = 7'($urandom_range(15, 0)); inv_adr = a;
      inv_req = ($urandom_range(5, 0) == 0);
      inv_all = ($urandom_range(40, 0) == 0);
      tick();
    end
    idle_inputs();
    repeat (LINES + 10) tick();

    // Invalidate-all over a populated array: busy span, single done pulse, all clear after
    for (int i = 0; i < 8; i++) begin
      fill_wr = 1; fill_way = 2'(i); fill_adr = 32'(i * 9) << LOBIT; tick();
    end
    fill_wr = 0; inv_req = 1; inv_all = 1; tick();
    idle_inputs();
    busy_cnt = busy ? 1 : 0; done_n = 0; done_k = -1;
    for (int k = 1; k <= LINES + 10; k++) begin
      tick();
      if (busy) busy_cnt++;
      if (inv_done) begin done_n++; done_k = k; end
    end
    chk("invall_busy_cycles", 32'(busy_cnt), 32'(INVALL_K));
    chk("invall_done_count", 32'(done_n), 1);
    chk("invall_done_cycle", 32'(done_k), 32'(INVALL_K));
    for (int i = 0; i < LINES; i++) begin
      lkp_adr = 32'(i) << LOBIT; tick();
      chk($sformatf("invall_clear_%0d", i), 32'(vld_o), 0);
    end

    // Queue fills up behind a sweep: four accepted, fifth refused, all four run after done
    inv_req = 1; inv_all = 1; tick();
    inv_all = 0;
    for (int i = 0; i < 5; i++) begin
      inv_adr = 32'(20 + i) << LOBIT; tick();
`ifndef RFPHOENIX_ICVALID_FASTINV_EN
      chk($sformatf("qfull_rdy_%0d", i), 32'(inv_rdy), (i >= 3) ? 0 : 1);
`endif
    end
    idle_inputs();
    done_n = 0;
    for (int k = 0; k < LINES + 10 && done_n == 0; k++) begin
      tick();
      if (inv_done) done_n++;
    end
`ifndef RFPHOENIX_ICVALID_FASTINV_EN
    chk("qfull_done_seen", 32'(done_n), 1);
    tick(); tick(); tick();
    chk("qfull_busy_3rd", 32'(busy), 1);
    tick();
    chk("qfull_busy_4th", 32'(busy), 0);
`endif
    repeat (4) tick();

    // Reset while the sweep is at ptr=40
    fill_wr = 1; fill_way = 2; fill_adr = 32'(100) << LOBIT; tick();
    fill_wr = 0; inv_req = 1; inv_all = 1; tick();
    idle_inputs();
    repeat (41) tick();
    rst = 1; model_reset();
    #1;
    chk("midrst_vld", 32'(vld_o), 0);
    chk("midrst_done", 32'(inv_done), 0);
    chk("midrst_rdy", 32'(inv_rdy), 1);
    chk("midrst_busy", 32'(busy), 0);
    #1 rst = 0;
    done_n = 0;
    lkp_adr = 32'(100) << LOBIT;
    for (int k = 0; k < LINES + 5; k++) begin
      tick();
      if (inv_done) done_n++;
    end
    chk("midrst_no_done", 32'(done_n), 0);
    chk("midrst_array_clear", 32'(vld_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
